// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - ISA constants: opcodes, control bit positions, ALU ops, field slices
package isa_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 8;
    localparam int REG_AW    = 3;
    localparam int CTRL_W    = 11;
    localparam int INSTR_W   = 32;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_NOP  = 5'b00000;
    localparam opcode_t OP_NOT  = 5'b00001;
    localparam opcode_t OP_INC  = 5'b00010;
    localparam opcode_t OP_MOV  = 5'b00011;
    localparam opcode_t OP_ADD  = 5'b00100;
    localparam opcode_t OP_SUB  = 5'b00101;
    localparam opcode_t OP_AND  = 5'b00110;
    localparam opcode_t OP_OR   = 5'b00111;
    localparam opcode_t OP_IADD = 5'b01000;
    localparam opcode_t OP_LDM  = 5'b01001;
    localparam opcode_t OP_LDD  = 5'b01010;
    localparam opcode_t OP_STD  = 5'b01011;
    localparam opcode_t OP_OUT  = 5'b01100;
    localparam opcode_t OP_IN   = 5'b01101;
    localparam opcode_t OP_JMP  = 5'b01110;

    localparam int CTRL_REGWRITE  = 10;
    localparam int CTRL_MEMREAD   = 9;
    localparam int CTRL_MEMWRITE  = 8;
    localparam int CTRL_MEMTOREG  = 7;
    localparam int CTRL_ALUSRCIMM = 6;
    localparam int CTRL_ALUOP_LSB = 3;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_OUTEN     = 1;
    localparam int CTRL_INEN      = 0;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_INC  = 3'b110;
    localparam logic [2:0] ALU_MOV  = 3'b111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 27;
    localparam int RDST_MSB   = 26;
    localparam int RDST_LSB   = 24;
    localparam int RSRC1_MSB  = 23;
    localparam int RSRC1_LSB  = 21;
    localparam int RSRC2_MSB  = 20;
    localparam int RSRC2_LSB  = 18;

    function automatic logic [CTRL_W-1:0] ctrl_word(
        input logic       reg_write,
        input logic       mem_read,
        input logic       mem_write,
        input logic       mem_to_reg,
        input logic       alu_src_imm,
        input logic [2:0] alu_op,
        input logic       branch,
        input logic       out_en,
        input logic       in_en
    );
        logic [CTRL_W-1:0] c;
        c                          = '0;
        c[CTRL_REGWRITE]           = reg_write;
        c[CTRL_MEMREAD]            = mem_read;
        c[CTRL_MEMWRITE]           = mem_write;
        c[CTRL_MEMTOREG]           = mem_to_reg;
        c[CTRL_ALUSRCIMM]          = alu_src_imm;
        c[CTRL_ALUOP_LSB +: 3]     = alu_op;
        c[CTRL_BRANCH]             = branch;
        c[CTRL_OUTEN]              = out_en;
        c[CTRL_INEN]               = in_en;
        return c;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// rtl/decode_stage_if.sv - decode stage bus: instruction/writeback in, control and operands out
interface decode_stage_if;
    import isa_pkg::*;

    logic [INSTR_W-1:0] instruction;
    logic [REG_AW-1:0]  writeAddress;
    logic               writeEnable;
    logic [DATA_W-1:0]  writeData;
    logic [CTRL_W-1:0]  controlSignal;
    logic [DATA_W-1:0]  readData1;
    logic [DATA_W-1:0]  readData2;

    modport master (
        output instruction, writeAddress, writeEnable, writeData,
        input  controlSignal, readData1, readData2
    );

    modport slave (
        input  instruction, writeAddress, writeEnable, writeData,
        output controlSignal, readData1, readData2
    );
endinterface

// File: rtl/decode_stage_register_file.sv
// rtl/decode_stage_register_file.sv - 8x16 register file, async clear, two bypassed read ports
module register_file
    import isa_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [DATA_W-1:0] rd1_o,
    output logic [DATA_W-1:0] rd2_o
);
    logic [DATA_W-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Bypass lets the same-cycle consumer see the value being written back.
    always_comb begin
        rd1_o = '0;
        rd2_o = '0;
        if (!rst) begin
            rd1_o = (we_i && (wa_i == ra1_i)) ? wd_i : regs_q[ra1_i];
            rd2_o = (we_i && (wa_i == ra2_i)) ? wd_i : regs_q[ra2_i];
        end
    end
endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode: opcode to control bundle plus register operand reads
module decode_stage
    import isa_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    opcode_t           opcode;
    logic [CTRL_W-1:0] ctrl;
    logic              unused_fields;

    assign opcode        = bus.instruction[OPCODE_MSB:OPCODE_LSB];
    assign unused_fields = ^{bus.instruction[RDST_MSB:RDST_LSB], bus.instruction[17:0]};

    register_file u_register_file (
        .clk   (clk),
        .rst   (rst),
        .we_i  (bus.writeEnable),
        .wa_i  (bus.writeAddress),
        .wd_i  (bus.writeData),
        .ra1_i (bus.instruction[RSRC1_MSB:RSRC1_LSB]),
        .ra2_i (bus.instruction[RSRC2_MSB:RSRC2_LSB]),
        .rd1_o (bus.readData1),
        .rd2_o (bus.readData2)
    );

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            unique case (opcode)
                OP_NOT:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_NOT,  0, 0, 0);
                OP_INC:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_INC,  0, 0, 0);
                OP_MOV:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_MOV,  0, 0, 0);
                OP_ADD:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_ADD,  0, 0, 0);
                OP_SUB:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_SUB,  0, 0, 0);
                OP_AND:  ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_AND,  0, 0, 0);
                OP_OR:   ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_OR,   0, 0, 0);
                OP_IADD: ctrl = ctrl_word(1, 0, 0, 0, 1, ALU_ADD,  0, 0, 0);
                OP_LDM:  ctrl = ctrl_word(1, 0, 0, 0, 1, ALU_MOV,  0, 0, 0);
                OP_LDD:  ctrl = ctrl_word(1, 1, 0, 1, 1, ALU_ADD,  0, 0, 0);
                OP_STD:  ctrl = ctrl_word(0, 0, 1, 0, 1, ALU_ADD,  0, 0, 0);
                OP_OUT:  ctrl = ctrl_word(0, 0, 0, 0, 0, ALU_NONE, 0, 1, 0);
                OP_IN:   ctrl = ctrl_word(1, 0, 0, 0, 0, ALU_NONE, 0, 0, 1);
                OP_JMP:  ctrl = ctrl_word(0, 0, 0, 0, 0, ALU_NONE, 1, 0, 0);
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.controlSignal = ctrl;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a register-array model
module tb_decode_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [15:0] model_regs [8];
    logic [10:0] exp_ctrl   [32];

    decode_stage_if bif ();

    decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [4:0] op, input logic [2:0] rd,
                                             input logic [2:0] rs1, input logic [2:0] rs2,
                                             input logic [15:0] imm);
        return {op, rd, rs1, rs2, 2'b00, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected outputs derived from the model and the currently driven inputs.
    task automatic check_outputs(input string tag);
        logic [2:0]  ra1, ra2;
        logic [15:0] e1, e2;
        logic [10:0] ec;
        ra1 = bif.instruction[23:21];
        ra2 = bif.instruction[20:18];
        if (rst) begin
            e1 = 16'h0; e2 = 16'h0; ec = 11'h0;
        end else begin
            e1 = (bif.writeEnable && bif.writeAddress == ra1) ? bif.writeData : model_regs[ra1];
            e2 = (bif.writeEnable && bif.writeAddress == ra2) ? bif.writeData : model_regs[ra2];
            ec = exp_ctrl[bif.instruction[31:27]];
        end
        chk({tag, ".rd1"}, {16'h0, bif.readData1}, {16'h0, e1});
        chk({tag, ".rd2"}, {16'h0, bif.readData2}, {16'h0, e2});
        chk({tag, ".ctrl"}, {21'h0, bif.controlSignal}, {21'h0, ec});
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst && bif.writeEnable) model_regs[bif.writeAddress] = bif.writeData;
        @(negedge clk);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
        bif.writeEnable  = 1'b1;
        bif.writeAddress = a;
        bif.writeData    = d;
        step();
        bif.writeEnable  = 1'b0;
    endtask

    task automatic read_all(input string tag);
        for (int r = 0; r < 8; r++) begin
            bif.instruction = mk_instr(5'b00000, 3'd0, r[2:0], r[2:0], 16'h0);
            #1;
            check_outputs($sformatf("%s.r%0d", tag, r));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk    = 1'b0;
        for (int i = 0; i < 32; i++) exp_ctrl[i] = 11'h000;
        exp_ctrl[1]  = 11'h428; exp_ctrl[2]  = 11'h430; exp_ctrl[3]  = 11'h438;
        exp_ctrl[4]  = 11'h408; exp_ctrl[5]  = 11'h410; exp_ctrl[6]  = 11'h418;
        exp_ctrl[7]  = 11'h420; exp_ctrl[8]  = 11'h448; exp_ctrl[9]  = 11'h478;
        exp_ctrl[10] = 11'h6C8; exp_ctrl[11] = 11'h148; exp_ctrl[12] = 11'h002;
        exp_ctrl[13] = 11'h401; exp_ctrl[14] = 11'h004;
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;

        // Reset with all-ones instruction and a bypass-eligible write pending.
        rst              = 1'b1;
        bif.instruction  = 32'hFFFF_FFFF;
        bif.writeEnable  = 1'b1;
        bif.writeAddress = 3'd7;
        bif.writeData    = 16'h1234;
        #1;
        check_outputs("reset");
        chk("reset.ctrl_zero", {21'h0, bif.controlSignal}, 32'h0);
        chk("reset.rd1_zero", {16'h0, bif.readData1}, 32'h0);
        step();
        step();
        bif.writeEnable = 1'b0;
        rst = 1'b0;
        #1;
        read_all("post_reset");

        // Directed write then read through opcode 10101.
        write_reg(3'd5, 16'h5555);
        bif.instruction = 32'hAAAA_AAAA;
        #1;
        check_outputs("wr_rd");
        chk("wr_rd.r5", {16'h0, bif.readData1}, 32'h5555);

        // Bypass on R0 to both ports, then the value persists.
        bif.instruction  = 32'h0;
        bif.writeEnable  = 1'b1;
        bif.writeAddress = 3'd0;
        bif.writeData    = 16'hFFFF;
        #1;
        check_outputs("bypass");
        chk("bypass.rd2", {16'h0, bif.readData2}, 32'h0000FFFF);
        step();
        bif.writeEnable = 1'b0;
        #1;
        check_outputs("bypass_hold");
        chk("bypass_hold.rd1", {16'h0, bif.readData1}, 32'h0000FFFF);

        // Decode sweep across every opcode.
        for (int op = 0; op < 32; op++) begin
            bif.instruction = mk_instr(op[4:0], 3'd0, 3'd0, 3'd0, 16'h0);
            #1;
            check_outputs($sformatf("sweep.op%0d", op));
        end

        // Write disabled must not touch R7.
        bif.writeEnable  = 1'b0;
        bif.writeAddress = 3'd7;
        bif.writeData    = 16'h5555;
        step();
        step();
        bif.instruction = mk_instr(5'b00000, 3'd0, 3'd7, 3'd7, 16'h0);
        #1;
        check_outputs("wdis");
        chk("wdis.r7", {16'h0, bif.readData1}, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            bif.instruction  = $urandom;
            bif.writeEnable  = 1'($urandom_range(0, 1));
            bif.writeAddress = 3'($urandom_range(0, 7));
            bif.writeData    = 16'($urandom);
            #1;
            check_outputs($sformatf("rand%0d", n));
            step();
        end
        bif.writeEnable = 1'b0;

        // Fill all registers, then reset between edges.
        for (int r = 0; r < 8; r++) write_reg(r[2:0], 16'hA000 + 16'(r * 16'h0111));
        #1;
        read_all("filled");
        #2;
        bif.writeEnable  = 1'b1;
        bif.writeAddress = 3'd3;
        bif.writeData    = 16'hABCD;
        rst = 1'b1;
        for (int i = 0; i < 8; i++) model_regs[i] = 16'h0;
        #1;
        read_all("mid_reset");
        step();
        rst = 1'b0;
        bif.writeEnable = 1'b0;
        #1;
        read_all("after_mid_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
